// File: rtl/axi_interconnect_crossbar_sreq_route_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_interconnect_crossbar_sreq_route_if
// Description : Bundle of the source request, target request and ordering
//               queue signals seen by one source-side request router.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_interconnect_crossbar_sreq_route_if #(
  parameter int NUM_TARGET    = 4,
  parameter int WIDTH_ID      = 4,
  parameter int WIDTH_SRC     = 2,
  parameter int WIDTH_ADDR    = 32,
  parameter int WIDTH_REQINFO = 48
);
  // Upstream source request
  logic [WIDTH_ADDR-1:0]                      s_req_addr;
  logic [WIDTH_ID-1:0]                        s_req_id;
  logic [WIDTH_REQINFO-1:0]                   s_req_info;
  logic                                       s_req_valid;
  logic                                       s_req_ready;
  // Downstream target lanes (payload shared, valid one-hot)
  logic [WIDTH_ADDR-1:0]                      m_req_addr;
  logic [WIDTH_ID-1:0]                        m_req_id;
  logic [WIDTH_REQINFO-1:0]                   m_req_info;
  logic [NUM_TARGET-1:0]                      m_req_valid;
  logic [NUM_TARGET-1:0]                      m_req_ready;
  // Response-ordering queue push and status
  logic                                       req_wren;
  logic [NUM_TARGET+WIDTH_ID+WIDTH_SRC:0]     req_id;
  logic                                       resp_done;
  logic [4:0]                                 ost_cnt;
  logic                                       dec_err;

  // Router side
  modport master (
    input  s_req_addr, s_req_id, s_req_info, s_req_valid,
    output s_req_ready,
    output m_req_addr, m_req_id, m_req_info, m_req_valid,
    input  m_req_ready,
    output req_wren, req_id,
    input  resp_done,
    output ost_cnt, dec_err
  );

  // Environment side (source, targets, response arbiter)
  modport slave (
    output s_req_addr, s_req_id, s_req_info, s_req_valid,
    input  s_req_ready,
    input  m_req_addr, m_req_id, m_req_info, m_req_valid,
    output m_req_ready,
    input  req_wren, req_id,
    output resp_done,
    input  ost_cnt, dec_err
  );
endinterface
`default_nettype wire

// File: rtl/axi_interconnect_crossbar_sreq_route.sv
`default_nettype none
// ============================================================================
// Module      : axi_interconnect_crossbar_sreq_route
// Description : Request-side router for one crossbar source port. Decodes the
//               request address to a target lane, forwards the request with a
//               one-hot valid, pushes an ordering entry per issued request and
//               limits the number of outstanding transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_interconnect_crossbar_sreq_route #(
  parameter int                              NUM_TARGET      = 4,
  parameter int                              WIDTH_ID        = 4,
  parameter int                              WIDTH_SRC       = 2,
  parameter int                              SRC_INDEX       = 0,
  parameter int                              WIDTH_ADDR      = 32,
  parameter int                              WIDTH_REQINFO   = 48,
  parameter int                              NUM_OUTSTANDING = 4,
  parameter logic [NUM_TARGET*WIDTH_ADDR-1:0] ADDR_BASE      = '0,
  parameter logic [NUM_TARGET*WIDTH_ADDR-1:0] ADDR_MASK      = '0,
  parameter int                              U_DLY           = 1
) (
  input  wire logic                          clk_sys,
  input  wire logic                          rst,
  axi_interconnect_crossbar_sreq_route_if.master bus
);

  localparam logic [WIDTH_SRC-1:0] c_src_index = WIDTH_SRC'(SRC_INDEX);
  localparam logic [4:0]           c_max_ost   = 5'(NUM_OUTSTANDING);

  // Reject parameter sets outside the supported range at elaboration
  if (NUM_TARGET < 1 || NUM_TARGET > 4 || NUM_OUTSTANDING < 1 ||
      NUM_OUTSTANDING > 16 || U_DLY < 0) begin : g_param_check
    $error("axi_interconnect_crossbar_sreq_route: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t                     r_state;
  logic [WIDTH_ADDR-1:0]      r_addr;
  logic [WIDTH_ID-1:0]        r_id;
  logic [WIDTH_REQINFO-1:0]   r_info;
  logic [NUM_TARGET-1:0]      r_onehot;
  logic                       r_err;
  logic [4:0]                 r_ost_cnt;

  logic [NUM_TARGET-1:0]      w_dec_onehot;
  logic                       w_dec_err;
  logic                       w_blocked;
  logic [NUM_TARGET-1:0]      w_lane_valid;
  logic                       w_issue_hs;
  logic                       w_err_push;
  logic                       w_wren;

  // Address decode: scan from the top so the lowest matching index wins
  always_comb begin
    w_dec_onehot = '0;
    w_dec_err    = 1'b1;
    for (int i = NUM_TARGET - 1; i >= 0; i--) begin
      if ((bus.s_req_addr & ADDR_MASK[i*WIDTH_ADDR +: WIDTH_ADDR]) ==
          ADDR_BASE[i*WIDTH_ADDR +: WIDTH_ADDR]) begin
        w_dec_onehot    = '0;
        w_dec_onehot[i] = 1'b1;
        w_dec_err       = 1'b0;
      end
    end
  end

  // Blocking uses the registered count, so a same-cycle resp_done cannot unblock
  assign w_blocked    = (r_ost_cnt == c_max_ost);
  assign w_lane_valid = ((r_state == ST_ISSUE) && !w_blocked) ? r_onehot : '0;
  assign w_issue_hs   = |(w_lane_valid & bus.m_req_ready);
  assign w_err_push   = (r_state == ST_ERR) && !w_blocked;
  assign w_wren       = w_issue_hs || w_err_push;

  assign bus.s_req_ready = (r_state == ST_IDLE);
  assign bus.m_req_addr  = r_addr;
  assign bus.m_req_id    = r_id;
  assign bus.m_req_info  = r_info;
  assign bus.m_req_valid = w_lane_valid;
  assign bus.req_wren    = w_wren;
  assign bus.req_id      = {r_err, r_onehot, r_id, c_src_index};
  assign bus.ost_cnt     = r_ost_cnt;
  assign bus.dec_err     = w_err_push;

  // Request FSM: capture on accept, hold until issued or error entry pushed
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_id     <= '0;
      r_info   <= '0;
      r_onehot <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.s_req_valid) begin
            r_addr   <= bus.s_req_addr;
            r_id     <= bus.s_req_id;
            r_info   <= bus.s_req_info;
            r_onehot <= w_dec_onehot;
            r_err    <= w_dec_err;
            r_state  <= w_dec_err ? ST_ERR : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_issue_hs) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (w_err_push) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding counter: +1 per queue push, -1 per completed response, floor at 0
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_ost_cnt <= '0;
    end else begin
      case ({w_wren, bus.resp_done})
        2'b10:   r_ost_cnt <= r_ost_cnt + 5'd1;
        2'b01:   if (r_ost_cnt != 5'd0) r_ost_cnt <= r_ost_cnt - 5'd1;
        default: r_ost_cnt <= r_ost_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_interconnect_crossbar_sreq_route.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_interconnect_crossbar_sreq_route
// Description : Scoreboard bench for the source request router. Directed
//               requests push expected ordering entries; a negedge monitor
//               pops and compares whenever the router pushes an entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_interconnect_crossbar_sreq_route;

  localparam logic [127:0] c_base = {32'h2000_0000, 32'h0000_1000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] c_mask = {32'hF000_0000, 32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000};

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [10:0] rid;
    logic [3:0]  lanes;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [47:0] info;
  } exp_t;

  exp_t sb[$];

  axi_interconnect_crossbar_sreq_route_if #(
    .NUM_TARGET(4), .WIDTH_ID(4), .WIDTH_SRC(2), .WIDTH_ADDR(32), .WIDTH_REQINFO(48)
  ) ifc ();

  axi_interconnect_crossbar_sreq_route #(
    .NUM_TARGET(4), .WIDTH_ID(4), .WIDTH_SRC(2), .SRC_INDEX(0), .WIDTH_ADDR(32),
    .WIDTH_REQINFO(48), .NUM_OUTSTANDING(2), .ADDR_BASE(c_base), .ADDR_MASK(c_mask),
    .U_DLY(1)
  ) dut (
    .clk_sys(clk_sys),
    .rst(rst),
    .bus(ifc.master)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_push(input logic err, input logic [3:0] lanes, input logic [31:0] a,
                             input logic [3:0] id, input logic [47:0] info);
    exp_t e;
    e.rid   = {err, lanes, id, 2'd0};
    e.lanes = lanes;
    e.addr  = a;
    e.id    = id;
    e.info  = info;
    sb.push_back(e);
  endtask

  // Present one request; returns #1 after the accepting edge
  task automatic send(input logic [31:0] a, input logic [3:0] id, input logic [47:0] info);
    int n;
    n = 0;
    while (!ifc.s_req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready_wait", {63'd0, ifc.s_req_ready}, 64'd1);
    ifc.s_req_addr  = a;
    ifc.s_req_id    = id;
    ifc.s_req_info  = info;
    ifc.s_req_valid = 1'b1;
    tick();
    ifc.s_req_valid = 1'b0;
  endtask

  task automatic drain(input int k);
    repeat (k) begin
      ifc.resp_done = 1'b1;
      tick();
    end
    ifc.resp_done = 1'b0;
  endtask

  // Monitor: every queue push must match the oldest expected entry
  always @(negedge clk_sys) begin
    if (!rst && ifc.req_wren) begin
      if (sb.size() == 0) begin
        chk("unexpected_wren", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("req_id", {53'd0, ifc.req_id}, {53'd0, e.rid});
        chk("push_lanes", {60'd0, ifc.m_req_valid}, {60'd0, e.lanes});
        chk("dec_err", {63'd0, ifc.dec_err}, {63'd0, e.rid[10]});
        if (!e.rid[10]) begin
          chk("m_req_addr", {32'd0, ifc.m_req_addr}, {32'd0, e.addr});
          chk("m_req_id", {60'd0, ifc.m_req_id}, {60'd0, e.id});
          chk("m_req_info", {16'd0, ifc.m_req_info}, {16'd0, e.info});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.s_req_addr  = '0;
    ifc.s_req_id    = '0;
    ifc.s_req_info  = '0;
    ifc.s_req_valid = 1'b0;
    ifc.m_req_ready = '0;
    ifc.resp_done   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_m_req_valid", {60'd0, ifc.m_req_valid}, 64'd0);
    chk("rst_req_wren", {63'd0, ifc.req_wren}, 64'd0);
    chk("rst_ost_cnt", {59'd0, ifc.ost_cnt}, 64'd0);
    chk("rst_dec_err", {63'd0, ifc.dec_err}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {63'd0, ifc.s_req_ready}, 64'd1);

    // Basic decode to target 1
    ifc.m_req_ready = 4'b0010;
    expect_push(1'b0, 4'b0010, 32'h1000_0040, 4'h3, 48'h0123_4567_89AB);
    send(32'h1000_0040, 4'h3, 48'h0123_4567_89AB);
    chk("t1_valid_n1", {60'd0, ifc.m_req_valid}, 64'h2);
    tick();
    chk("t1_ost", {59'd0, ifc.ost_cnt}, 64'd1);

    // Overlap t0/t2 picks t0; push coincides with resp_done at ost 1
    ifc.m_req_ready = 4'b1111;
    expect_push(1'b0, 4'b0001, 32'h0000_1000, 4'h5, 48'hAAAA_5555_0001);
    send(32'h0000_1000, 4'h5, 48'hAAAA_5555_0001);
    chk("overlap_valid", {60'd0, ifc.m_req_valid}, 64'h1);
    ifc.resp_done = 1'b1;
    tick();
    ifc.resp_done = 1'b0;
    chk("simul_ost", {59'd0, ifc.ost_cnt}, 64'd1);
    drain(1);
    chk("drain_ost0", {59'd0, ifc.ost_cnt}, 64'd0);
    drain(1);
    chk("ost_floor0", {59'd0, ifc.ost_cnt}, 64'd0);

    // Unmapped address
    expect_push(1'b1, 4'b0000, 32'hF000_0000, 4'h7, 48'h0);
    send(32'hF000_0000, 4'h7, 48'h0);
    chk("err_no_valid", {60'd0, ifc.m_req_valid}, 64'd0);
    chk("err_dec_err", {63'd0, ifc.dec_err}, 64'd1);
    chk("err_wren", {63'd0, ifc.req_wren}, 64'd1);
    tick();
    chk("err_pulse_end", {63'd0, ifc.dec_err}, 64'd0);
    chk("err_ost", {59'd0, ifc.ost_cnt}, 64'd1);
    drain(1);

    // Outstanding limit of 2
    expect_push(1'b0, 4'b0010, 32'h1000_0000, 4'h1, 48'h1111_1111_1111);
    send(32'h1000_0000, 4'h1, 48'h1111_1111_1111);
    expect_push(1'b0, 4'b1000, 32'h2000_0010, 4'h2, 48'h2222_2222_2222);
    send(32'h2000_0010, 4'h2, 48'h2222_2222_2222);
    tick();
    chk("lim_ost2", {59'd0, ifc.ost_cnt}, 64'd2);
    expect_push(1'b0, 4'b0010, 32'h1000_0100, 4'h4, 48'h3333_3333_3333);
    send(32'h1000_0100, 4'h4, 48'h3333_3333_3333);
    chk("lim_blocked", {60'd0, ifc.m_req_valid}, 64'd0);
    chk("lim_not_ready", {63'd0, ifc.s_req_ready}, 64'd0);
    repeat (2) begin
      tick();
      chk("lim_still_blocked", {60'd0, ifc.m_req_valid}, 64'd0);
    end
    ifc.resp_done = 1'b1;
    chk("lim_done_same_cycle", {60'd0, ifc.m_req_valid}, 64'd0);
    tick();
    ifc.resp_done = 1'b0;
    chk("lim_ost1", {59'd0, ifc.ost_cnt}, 64'd1);
    chk("lim_released", {60'd0, ifc.m_req_valid}, 64'h2);
    tick();
    chk("lim_ost_back2", {59'd0, ifc.ost_cnt}, 64'd2);
    drain(2);
    chk("lim_drained", {59'd0, ifc.ost_cnt}, 64'd0);

    // Selected lane stalls 5 cycles; other lanes ready but ignored
    ifc.m_req_ready = 4'b1101;
    expect_push(1'b0, 4'b0010, 32'h1000_0ABC, 4'h9, 48'hDEAD_BEEF_CAFE);
    send(32'h1000_0ABC, 4'h9, 48'hDEAD_BEEF_CAFE);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {60'd0, ifc.m_req_valid}, 64'h2);
      chk("stall_addr", {32'd0, ifc.m_req_addr}, 64'h1000_0ABC);
      chk("stall_info", {16'd0, ifc.m_req_info}, 64'hDEAD_BEEF_CAFE);
      chk("stall_s_ready", {63'd0, ifc.s_req_ready}, 64'd0);
      chk("stall_no_wren", {63'd0, ifc.req_wren}, 64'd0);
      tick();
    end
    ifc.m_req_ready = 4'b1111;
    tick();
    chk("stall_done_idle", {63'd0, ifc.s_req_ready}, 64'd1);
    chk("stall_ost", {59'd0, ifc.ost_cnt}, 64'd1);
    chk("stall_valid_drop", {60'd0, ifc.m_req_valid}, 64'd0);

    // Asynchronous reset while a request waits in ISSUE
    ifc.m_req_ready = 4'b0000;
    send(32'h1000_0000, 4'h2, 48'h4444_4444_4444);
    chk("pre_rst_valid", {60'd0, ifc.m_req_valid}, 64'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {60'd0, ifc.m_req_valid}, 64'd0);
    chk("arst_ost", {59'd0, ifc.ost_cnt}, 64'd0);
    chk("arst_wren", {63'd0, ifc.req_wren}, 64'd0);
    chk("arst_addr", {32'd0, ifc.m_req_addr}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    ifc.m_req_ready = 4'b1111;
    repeat (3) tick();
    chk("post_rst_no_issue", {60'd0, ifc.m_req_valid}, 64'd0);
    chk("post_rst_ost", {59'd0, ifc.ost_cnt}, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
